// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 3x3 streaming filter.
package conv_pkg;

   // Widest pixel the accumulator below is sized for.
   localparam int PIX_W_DEF = 4;
   // Signed accumulator: 16 * max pixel (Gaussian sum) plus sign fits here.
   localparam int ACC_W = PIX_W_DEF + 5;

   typedef enum logic [1:0] {
      MODE_SOBEL = 2'd0,
      MODE_GAUSS = 2'd1,
      MODE_LAPL  = 2'd2,
      MODE_PASS  = 2'd3
   } mode_e;

   typedef logic signed [ACC_W-1:0] acc_t;

   // Clamp a signed accumulator into [0, max_v].
   function automatic logic [ACC_W-1:0] sat_u(input acc_t v, input logic [ACC_W-1:0] max_v);
      if (v[ACC_W-1]) return '0;
      if (unsigned'(v) > max_v) return max_v;
      return unsigned'(v);
   endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream in/out with valid/ready handshakes plus the kernel select.
interface conv3x3_stream_if #(parameter int PIX_W = 4);
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_pixel;
   logic             in_sof;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_pixel;
   logic             out_sof;
   logic             out_eol;

   // Source/sink side of the filter.
   modport master (
      output mode, in_valid, in_pixel, in_sof, out_ready,
      input  in_ready, out_valid, out_pixel, out_sof, out_eol
   );

   // The filter itself.
   modport slave (
      input  mode, in_valid, in_pixel, in_sof, out_ready,
      output in_ready, out_valid, out_pixel, out_sof, out_eol
   );
endinterface

// File: rtl/line_buffer2.sv
// Two-row line buffer addressed by column. A write pushes the new pixel into
// the row above and that row's old value into the row two above; reads show
// the contents before the write, so one address serves both.
module line_buffer2 #(
   parameter int PIX_W = 4,
   parameter int IMG_W = 640,
   localparam int AW   = $clog2(IMG_W)
)(
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] rd_up1,
   output logic [PIX_W-1:0] rd_up2
);

   logic [PIX_W-1:0] row_up1 [IMG_W];
   logic [PIX_W-1:0] row_up2 [IMG_W];

   assign rd_up1 = row_up1[addr];
   assign rd_up2 = row_up2[addr];

   // Contents are never cleared: windows touching stale rows are not emitted.
   always_ff @(posedge clk) begin
      if (en) begin
         row_up1[addr] <= wdata;
         row_up2[addr] <= row_up1[addr];
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 filter: raster counters, line buffer + window shift registers
// (stage 1), kernel compute and saturation into the output register (stage 2).
// The whole pipeline advances only when the output register can take data.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int PIX_W       = PIX_W_DEF,
   parameter int IMG_W       = 640,
   parameter int IMG_H       = 480,
   parameter int SOBEL_SHIFT = 2
)(
   input logic             clk,
   input logic             rst,
   conv3x3_stream_if.slave bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [ACC_W-1:0] MAX_V = ACC_W'((1 << PIX_W) - 1);

   if (IMG_W < 3) begin : g_chk_w
      $error("IMG_W must be at least 3");
   end
   if (IMG_H < 3) begin : g_chk_h
      $error("IMG_H must be at least 3");
   end
   if (PIX_W > PIX_W_DEF) begin : g_chk_pix
      $error("PIX_W exceeds the accumulator sizing in conv_pkg");
   end

   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic          accept, interior;
   mode_e         mode_q;

   logic [PIX_W-1:0]            up1, up2;
   logic [2:0][2:0][PIX_W-1:0]  win;   // [row: 0 top][col: 0 left]
   logic                        s1_vld, s1_sof, s1_eol;

   acc_t             gx, gy, sob, gau, lap;
   logic [PIX_W-1:0] res;

   // Pipeline moves only when the output slot is free or being drained.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // An SOF pixel is at (0,0) regardless of where the counters thought we were.
   assign cur_col  = bus.in_sof ? '0 : col;
   assign cur_row  = bus.in_sof ? '0 : row;
   assign interior = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

   // Raster position of the next expected pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (cur_col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
      end
   end

   // Kernel select is frozen per frame at the accepted SOF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mode_q <= MODE_SOBEL;
      else if (accept && bus.in_sof) mode_q <= mode_e'(bus.mode);
   end

   line_buffer2 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb (
      .clk    (clk),
      .en     (accept),
      .addr   (cur_col),
      .wdata  (bus.in_pixel),
      .rd_up1 (up1),
      .rd_up2 (up2)
   );

   // Shift the 3x3 window left and load the new column (r-2, r-1, r).
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= up2;
         win[1][2] <= up1;
         win[2][2] <= bus.in_pixel;
      end
   end

   // Stage-1 tags: window is valid once two rows and two columns are in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_sof <= 1'b0;
         s1_eol <= 1'b0;
      end else if (bus.in_ready) begin
         s1_vld <= accept && interior;
         s1_sof <= (cur_row == RW'(2)) && (cur_col == CW'(2));
         s1_eol <= (cur_col == CW'(IMG_W - 1));
      end
   end

   function automatic acc_t px(input logic [PIX_W-1:0] p);
      return acc_t'({{(ACC_W - PIX_W){1'b0}}, p});
   endfunction

   function automatic acc_t abs_s(input acc_t v);
      return v[ACC_W-1] ? -v : v;
   endfunction

   // All four kernels on the current window; mode_q picks one.
   always_comb begin
      gx = (px(win[0][2]) + (px(win[1][2]) <<< 1) + px(win[2][2]))
         - (px(win[0][0]) + (px(win[1][0]) <<< 1) + px(win[2][0]));
      gy = (px(win[0][0]) + (px(win[0][1]) <<< 1) + px(win[0][2]))
         - (px(win[2][0]) + (px(win[2][1]) <<< 1) + px(win[2][2]));
      sob = (abs_s(gx) + abs_s(gy)) >>> SOBEL_SHIFT;
      gau = (px(win[0][0]) + px(win[0][2]) + px(win[2][0]) + px(win[2][2])
           + ((px(win[0][1]) + px(win[1][0]) + px(win[1][2]) + px(win[2][1])) <<< 1)
           + (px(win[1][1]) <<< 2) + acc_t'(8)) >>> 4;
      lap = abs_s((px(win[1][1]) <<< 2) - px(win[0][1]) - px(win[2][1])
                  - px(win[1][0]) - px(win[1][2]));
      case (mode_q)
         MODE_SOBEL: res = PIX_W'(sat_u(sob, MAX_V));
         MODE_GAUSS: res = PIX_W'(sat_u(gau, MAX_V));
         MODE_LAPL:  res = PIX_W'(sat_u(lap, MAX_V));
         default:    res = win[1][1];
      endcase
   end

   // Output register; holds while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_sof   <= 1'b0;
         bus.out_eol   <= 1'b0;
         bus.out_pixel <= '0;
      end else if (bus.in_ready) begin
         bus.out_valid <= s1_vld;
         bus.out_sof   <= s1_vld && s1_sof;
         bus.out_eol   <= s1_vld && s1_eol;
         if (s1_vld) bus.out_pixel <= res;
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: directed frames with spot values, mid-stream
// reset, random backpressure/gaps against a frame-level reference model,
// and mid-frame mode change / SOF resync.
module tb_conv3x3_stream;

   localparam int PIX_W = 4, IMG_W = 8, IMG_H = 6, SOBEL_SHIFT = 2;
   localparam int NPIX = IMG_W * IMG_H;
   localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
   localparam int MAXP = (1 << PIX_W) - 1;
   // Trigger pixel (2,2) is number 2*W+3; output shows one accept later.
   localparam int SOF_LAT = 2 * IMG_W + 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   conv3x3_stream_if #(.PIX_W(PIX_W)) bus ();

   conv3x3_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SOBEL_SHIFT(SOBEL_SHIFT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int pix; bit sof; bit eol; } out_t;
   typedef struct { int pat; int mode; int r; int c; int exp; } vec_t;

   out_t got[$], exp_q[$];
   vec_t tbl[$];
   int   img      [IMG_H][IMG_W];
   int   got_grid [IMG_H][IMG_W];
   int   n_vec = 0, n_bad = 0;
   bit   stall_en = 1'b0;
   int   acc_cnt = 0, sof_lat = -1;
   bit   hold_prev = 1'b0;
   out_t held;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Filter value for the window centred at (r,c), straight from the kernel rules.
   function automatic int ref_pix(input int mode, input int r, input int c);
      int nw, n, ne, w, ctr, e, sw, s, se, gx, gy, v;
      nw = img[r-1][c-1]; n   = img[r-1][c]; ne = img[r-1][c+1];
      w  = img[r][c-1];   ctr = img[r][c];   e  = img[r][c+1];
      sw = img[r+1][c-1]; s   = img[r+1][c]; se = img[r+1][c+1];
      case (mode)
         0: begin
            gx = (ne + 2*e + se) - (nw + 2*w + sw);
            gy = (nw + 2*n + ne) - (sw + 2*s + se);
            v  = (iabs(gx) + iabs(gy)) / (1 << SOBEL_SHIFT);
         end
         1:       v = (nw + ne + sw + se + 2*(n + s + e + w) + 4*ctr + 8) / 16;
         2:       v = iabs(4*ctr - n - s - e - w);
         default: v = ctr;
      endcase
      return (v > MAXP) ? MAXP : v;
   endfunction

   // Expected outputs for the first n raster pixels of img.
   task automatic expect_stream(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         int r, c;
         r = i / IMG_W;
         c = i % IMG_W;
         if (r >= 2 && c >= 2)
            exp_q.push_back('{ref_pix(mode, r-1, c-1), (r-1 == 1 && c-1 == 1), (c-1 == IMG_W-2)});
      end
   endtask

   task automatic fill_img(input int pat);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            case (pat)
               0:       img[r][c] = 7;
               1:       img[r][c] = (c < 4) ? 0 : MAXP;
               2:       img[r][c] = (r == 3 && c == 3) ? MAXP : 0;
               default: img[r][c] = int'($urandom_range(0, MAXP));
            endcase
   endtask

   // Feed n pixels of img; mode switches to mode1 from pixel sw_idx on.
   task automatic send_stream(input int n, input int mode0, input int sw_idx, input int mode1, input bit gaps);
      int wc;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_pixel = PIX_W'(img[i / IMG_W][i % IMG_W]);
         bus.in_sof   = (i == 0);
         bus.mode     = 2'((i >= sw_idx) ? mode1 : mode0);
         wc = 0;
         forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            wc++;
            if (wc > 200) begin
               $display("FAIL accept_timeout: pixel %0d not accepted, required within 200 cycles", i);
               $fatal(1);
            end
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input string name);
      int k;
      k = 0;
      while (got.size() < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, " out_count"}, got.size(), n);
   endtask

   task automatic compare_all(input string name);
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
         check($sformatf("%s out%0d pixel", name, k), got[k].pix, exp_q[k].pix);
         check($sformatf("%s out%0d sof", name, k), int'(got[k].sof), int'(exp_q[k].sof));
         check($sformatf("%s out%0d eol", name, k), int'(got[k].eol), int'(exp_q[k].eol));
      end
   endtask

   task automatic run_frame(input int pat, input int mode, input bit gaps, input bit chk_lat, input string name);
      fill_img(pat);
      got.delete();
      exp_q.delete();
      expect_stream(NPIX, mode);
      sof_lat = -1;
      send_stream(NPIX, mode, NPIX, mode, gaps);
      wait_outputs(NOUT, name);
      compare_all(name);
      if (chk_lat) check({name, " sof_latency"}, sof_lat, SOF_LAT);
      for (int k = 0; k < got.size() && k < NOUT; k++)
         got_grid[1 + k / (IMG_W-2)][1 + k % (IMG_W-2)] = got[k].pix;
   endtask

   // Random downstream readiness when stalling is enabled.
   always @(posedge clk) begin
      #1;
      bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: capture transfers, handshake rule, hold-under-stall, SOF latency.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         check("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
         if (hold_prev) begin
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_pixel", int'(bus.out_pixel), held.pix);
            check("hold_sof", int'(bus.out_sof), int'(held.sof));
            check("hold_eol", int'(bus.out_eol), int'(held.eol));
         end
         if (bus.out_valid && bus.out_sof && sof_lat < 0) sof_lat = acc_cnt;
         if (bus.in_valid && bus.in_ready) acc_cnt = bus.in_sof ? 1 : acc_cnt + 1;
         if (bus.out_valid && bus.out_ready)
            got.push_back('{int'(bus.out_pixel), bus.out_sof, bus.out_eol});
         hold_prev = bus.out_valid && !bus.out_ready;
         held = '{int'(bus.out_pixel), bus.out_sof, bus.out_eol};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lp, lm;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_pixel  = '0;
      bus.mode      = 2'd0;
      bus.out_ready = 1'b1;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset out_valid", int'(bus.out_valid), 0);
      check("reset out_sof", int'(bus.out_sof), 0);
      check("reset out_eol", int'(bus.out_eol), 0);
      check("reset out_pixel", int'(bus.out_pixel), 0);
      check("reset in_ready", int'(bus.in_ready), 1);

      // pattern: 0 flat 7, 1 vertical step at col 4, 2 single dot at (3,3)
      tbl = '{
         '{0, 0, 1, 1, 0},  '{0, 0, 4, 6, 0},  '{0, 1, 2, 3, 7},  '{0, 1, 4, 6, 7},
         '{1, 0, 2, 3, 15}, '{1, 0, 3, 4, 15}, '{1, 0, 2, 2, 0},  '{1, 0, 4, 5, 0},
         '{2, 2, 3, 3, 15}, '{2, 2, 2, 3, 15}, '{2, 2, 4, 3, 15}, '{2, 2, 3, 2, 15},
         '{2, 2, 3, 4, 15}, '{2, 2, 2, 2, 0},  '{2, 2, 1, 1, 0},
         '{2, 1, 3, 3, 4},  '{2, 1, 2, 3, 2},  '{2, 1, 2, 2, 1},
         '{1, 3, 2, 4, 15}, '{1, 3, 2, 3, 0}
      };
      lp = -1;
      lm = -1;
      foreach (tbl[i]) begin
         if (tbl[i].pat != lp || tbl[i].mode != lm) begin
            run_frame(tbl[i].pat, tbl[i].mode, 1'b0, 1'b1,
                      $sformatf("frame p%0d m%0d", tbl[i].pat, tbl[i].mode));
            lp = tbl[i].pat;
            lm = tbl[i].mode;
         end
         check($sformatf("tbl%0d p%0d m%0d (%0d,%0d)", i, tbl[i].pat, tbl[i].mode, tbl[i].r, tbl[i].c),
               got_grid[tbl[i].r][tbl[i].c], tbl[i].exp);
      end

      // Reset while outputs are in flight.
      fill_img(0);
      got.delete();
      send_stream(30, 0, NPIX, 0, 1'b0);
      #2;
      check("pre_reset out_valid", int'(bus.out_valid), 1);
      rst = 1'b1;
      #1;
      check("async_reset out_valid", int'(bus.out_valid), 0);
      check("async_reset out_sof", int'(bus.out_sof), 0);
      check("async_reset out_pixel", int'(bus.out_pixel), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("post_reset in_ready", int'(bus.in_ready), 1);
      run_frame(0, 1, 1'b0, 1'b1, "after_reset");

      // Random backpressure and input gaps.
      stall_en = 1'b1;
      for (int f = 0; f < 6; f++)
         run_frame(3, int'($urandom_range(0, 3)), 1'b1, 1'b0, $sformatf("stall_frame%0d", f));
      stall_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Mode change mid-frame is ignored; SOF at (3,5) resyncs.
      fill_img(3);
      got.delete();
      exp_q.delete();
      expect_stream(3 * IMG_W + 5, 0);
      send_stream(3 * IMG_W + 5, 0, 10, 1, 1'b0);
      fill_img(3);
      expect_stream(NPIX, 1);
      sof_lat = -1;
      send_stream(NPIX, 1, NPIX, 1, 1'b0);
      wait_outputs(exp_q.size(), "resync");
      compare_all("resync");
      check("resync sof_latency", sof_lat, SOF_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
